// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings and
// control-FSM state encodings used by seq_alu and its control logic.
package alu_pkg;

  localparam logic [3:0] OP_LUI   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_SLL   = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SRL   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0101;
  localparam logic [3:0] OP_AND   = 4'b0110;
  localparam logic [3:0] OP_NOR   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_SLT   = 4'b1010;
  localparam logic [3:0] OP_SRA   = 4'b1011;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MUL  = 2'd1;
  localparam state_t ST_DIV  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative multiply / divide datapath, one bit per cycle.
// Multiply: unsigned shift-add on a {hi,lo} product register (lo starts as b).
// Divide (only when SEQ_ALU_DIV_EN is defined): unsigned restoring division,
// hi holds the partial remainder, lo shifts the dividend out and the quotient in.
// next_hi/next_lo present the value after one more step so the control unit
// can register the final result on the last iteration edge.
module seq_alu_muldiv #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
`ifdef SEQ_ALU_DIV_EN
  input  logic                  load_div,
`endif
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] next_hi,
  output logic [DATA_WIDTH-1:0] next_lo
);

  logic [DATA_WIDTH-1:0] work_hi_r;
  logic [DATA_WIDTH-1:0] work_lo_r;
  logic [DATA_WIDTH-1:0] opnd_r;
  logic [DATA_WIDTH:0]   mul_sum_s;
  logic [DATA_WIDTH-1:0] mul_hi_s;
  logic [DATA_WIDTH-1:0] mul_lo_s;

  // One shift-add multiply step: conditionally add the multiplicand, shift right.
  always_comb begin
    if (work_lo_r[0]) begin
      mul_sum_s = {1'b0, work_hi_r} + {1'b0, opnd_r};
    end else begin
      mul_sum_s = {1'b0, work_hi_r};
    end
    mul_hi_s = mul_sum_s[DATA_WIDTH:1];
    mul_lo_s = {mul_sum_s[0], work_lo_r[DATA_WIDTH-1:1]};
  end

`ifdef SEQ_ALU_DIV_EN
  logic                  is_div_r;
  logic [DATA_WIDTH:0]   rem_sh_s;
  logic [DATA_WIDTH:0]   diff_s;
  logic [DATA_WIDTH-1:0] div_hi_s;
  logic [DATA_WIDTH-1:0] div_lo_s;

  // One restoring-division step; a zero divisor never borrows, giving an
  // all-ones quotient and the dividend as remainder.
  always_comb begin
    rem_sh_s = {work_hi_r, work_lo_r[DATA_WIDTH-1]};
    diff_s   = rem_sh_s - {1'b0, opnd_r};
    if (!diff_s[DATA_WIDTH]) begin
      div_hi_s = diff_s[DATA_WIDTH-1:0];
      div_lo_s = {work_lo_r[DATA_WIDTH-2:0], 1'b1};
    end else begin
      div_hi_s = rem_sh_s[DATA_WIDTH-1:0];
      div_lo_s = {work_lo_r[DATA_WIDTH-2:0], 1'b0};
    end
  end

  // Select the step result for the operation in flight.
  always_comb begin
    if (is_div_r) begin
      next_hi = div_hi_s;
      next_lo = div_lo_s;
    end else begin
      next_hi = mul_hi_s;
      next_lo = mul_lo_s;
    end
  end

  // Working registers: load operands at acceptance, then advance one step per cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      work_hi_r <= {DATA_WIDTH{1'b0}};
      work_lo_r <= {DATA_WIDTH{1'b0}};
      opnd_r    <= {DATA_WIDTH{1'b0}};
      is_div_r  <= 1'b0;
    end else if (load) begin
      work_hi_r <= {DATA_WIDTH{1'b0}};
      work_lo_r <= load_div ? a : b;
      opnd_r    <= load_div ? b : a;
      is_div_r  <= load_div;
    end else if (step) begin
      work_hi_r <= next_hi;
      work_lo_r <= next_lo;
    end else begin
      work_hi_r <= work_hi_r;
      work_lo_r <= work_lo_r;
    end
  end
`else
  // Multiply is the only iterative operation in this build.
  always_comb begin
    next_hi = mul_hi_s;
    next_lo = mul_lo_s;
  end

  // Working registers: load operands at acceptance, then advance one step per cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      work_hi_r <= {DATA_WIDTH{1'b0}};
      work_lo_r <= {DATA_WIDTH{1'b0}};
      opnd_r    <= {DATA_WIDTH{1'b0}};
    end else if (load) begin
      work_hi_r <= {DATA_WIDTH{1'b0}};
      work_lo_r <= b;
      opnd_r    <= a;
    end else if (step) begin
      work_hi_r <= next_hi;
      work_lo_r <= next_lo;
    end else begin
      work_hi_r <= work_hi_r;
      work_lo_r <= work_lo_r;
    end
  end
`endif

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU top: single-cycle datapath, control FSM and registered outputs.
// MULTU (and DIVU when SEQ_ALU_DIV_EN is defined) run for DATA_WIDTH cycles in
// seq_alu_muldiv; without SEQ_ALU_DIV_EN, DIVU behaves as an undefined opcode.
module seq_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [3:0]             alu_operation_i,
  input  logic [DATA_WIDTH-1:0]  a_i,
  input  logic [DATA_WIDTH-1:0]  b_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [DATA_WIDTH-1:0]  alu_data_o,
  output logic                   zero_o,
  output logic [DATA_WIDTH-1:0]  hi_o,
  output logic [DATA_WIDTH-1:0]  lo_o
);

  localparam int HALF  = DATA_WIDTH / 2;
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  state_t                state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  busy_r;
  logic                  done_r;
  logic [DATA_WIDTH-1:0] alu_r;
  logic                  zero_r;
  logic [DATA_WIDTH-1:0] hi_r;
  logic [DATA_WIDTH-1:0] lo_r;

  logic                  accept_s;
  logic                  load_s;
  logic                  load_div_s;
  logic                  step_s;
  logic [DATA_WIDTH-1:0] single_s;
  logic [DATA_WIDTH-1:0] next_hi_s;
  logic [DATA_WIDTH-1:0] next_lo_s;

  // New requests are taken whenever no iteration is running, including the done cycle.
  assign accept_s = start_i && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign step_s   = (state_r == ST_MUL) || (state_r == ST_DIV);

  // Single-cycle result for the current opcode; iterative and undefined opcodes give zero.
  always_comb begin
    case (alu_operation_i)
      OP_LUI:  single_s = {b_i[HALF-1:0], {HALF{1'b0}}};
      OP_OR:   single_s = a_i | b_i;
      OP_SLL:  single_s = b_i << shamt_i;
      OP_ADD:  single_s = a_i + b_i;
      OP_SRL:  single_s = b_i >> shamt_i;
      OP_SUB:  single_s = a_i - b_i;
      OP_AND:  single_s = a_i & b_i;
      OP_NOR:  single_s = ~(a_i | b_i);
      OP_SLT:  single_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SRA:  single_s = $signed(b_i) >>> shamt_i;
      default: single_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  // Decide whether an accepted request starts the iterative datapath.
  always_comb begin
    load_s     = 1'b0;
    load_div_s = 1'b0;
    if (accept_s && (alu_operation_i == OP_MULTU)) begin
      load_s = 1'b1;
`ifdef SEQ_ALU_DIV_EN
    end else if (accept_s && (alu_operation_i == OP_DIVU)) begin
      load_s     = 1'b1;
      load_div_s = 1'b1;
`endif
    end else begin
      load_s     = 1'b0;
      load_div_s = 1'b0;
    end
  end

  seq_alu_muldiv #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
`ifdef SEQ_ALU_DIV_EN
    .load_div (load_div_s),
`endif
    .step     (step_s),
    .a        (a_i),
    .b        (b_i),
    .next_hi  (next_hi_s),
    .next_lo  (next_lo_s)
  );

  // Control FSM and registered result outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      alu_r   <= {DATA_WIDTH{1'b0}};
      zero_r  <= 1'b1;
      hi_r    <= {DATA_WIDTH{1'b0}};
      lo_r    <= {DATA_WIDTH{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s && load_s) begin
            state_r <= load_div_s ? ST_DIV : ST_MUL;
            busy_r  <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
          end else if (accept_s) begin
            state_r <= ST_IDLE;
            alu_r   <= single_s;
            zero_r  <= (single_s == {DATA_WIDTH{1'b0}});
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt_r == LAST_CNT) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            hi_r    <= next_hi_s;
            lo_r    <= next_lo_s;
            alu_r   <= next_lo_s;
            zero_r  <= (next_lo_s == {DATA_WIDTH{1'b0}});
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign alu_data_o = alu_r;
  assign zero_o     = zero_r;
  assign hi_o       = hi_r;
  assign lo_o       = lo_r;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (DATA_WIDTH=32): table of single-cycle vectors,
// hand-written multi-cycle sequences, and a done_o-driven scoreboard.
module tb_seq_alu;

  localparam logic [3:0] OP_LUI   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_SLL   = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SRL   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0101;
  localparam logic [3:0] OP_AND   = 4'b0110;
  localparam logic [3:0] OP_NOR   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_SLT   = 4'b1010;
  localparam logic [3:0] OP_SRA   = 4'b1011;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [3:0]  alu_operation_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [4:0]  shamt_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] alu_data_o;
  logic        zero_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  seq_alu #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .alu_operation_i (alu_operation_i),
    .a_i             (a_i),
    .b_i             (b_i),
    .shamt_i         (shamt_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .alu_data_o      (alu_data_o),
    .zero_o          (zero_o),
    .hi_o            (hi_o),
    .lo_o            (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] alu;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zero;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          passes = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;
  logic [63:0] prod;
  vec_t        tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_exp(input string name, input logic [31:0] alu,
                          input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.name = name; e.alu = alu; e.hi = hi; e.lo = lo; e.zero = (alu == 32'h0);
    exp_q.push_back(e);
  endtask

  // Scoreboard: every done_o pulse is compared against the oldest expectation.
  always @(negedge clk) begin
    if (reset && done_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got done_o=1 expected no pulse, alu=%0h", alu_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk({mon_e.name, "_alu"},  {32'h0, alu_data_o}, {32'h0, mon_e.alu});
        chk({mon_e.name, "_zero"}, {63'h0, zero_o},     {63'h0, mon_e.zero});
        chk({mon_e.name, "_hi"},   {32'h0, hi_o},       {32'h0, mon_e.hi});
        chk({mon_e.name, "_lo"},   {32'h0, lo_o},       {32'h0, mon_e.lo});
      end
    end
  end

  // Issue one operation, scramble inputs while it runs, and check latency and busy.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic [31:0] e_alu,
                        input int e_lat, input bit poke);
    int cyc;
    bit busy_ok;
    push_exp(name, e_alu, m_hi, m_lo);
    @(negedge clk);
    alu_operation_i = op; a_i = a; b_i = b; shamt_i = sh; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; a_i = $urandom; b_i = $urandom; shamt_i = 5'($urandom);
    cyc = 1; busy_ok = 1'b1;
    while (!done_o && cyc < 100) begin
      if (!busy_o) busy_ok = 1'b0;
      if (poke && cyc == 5) begin
        start_i = 1'b1; alu_operation_i = OP_ADD;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    chk({name, "_latency"}, 64'(cyc), 64'(e_lat));
    chk({name, "_busy_at_done"}, {63'h0, busy_o}, 64'h0);
    if (e_lat > 1) chk({name, "_busy_while_running"}, {63'h0, busy_ok}, 64'h1);
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_busy"}, {63'h0, busy_o},     64'h0);
    chk({name, "_done"}, {63'h0, done_o},     64'h0);
    chk({name, "_alu"},  {32'h0, alu_data_o}, 64'h0);
    chk({name, "_zero"}, {63'h0, zero_o},     64'h1);
    chk({name, "_hi"},   {32'h0, hi_o},       64'h0);
    chk({name, "_lo"},   {32'h0, lo_o},       64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    tbl[0]  = '{"add_wrap",  OP_ADD, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000};
    tbl[1]  = '{"sra_neg",   OP_SRA, 32'h0,        32'h80000000, 5'd4,  32'hF8000000};
    tbl[2]  = '{"slt_true",  OP_SLT, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001};
    tbl[3]  = '{"lui",       OP_LUI, 32'h0,        32'hABCD1234, 5'd0,  32'h12340000};
    tbl[4]  = '{"or",        OP_OR,  32'h0F0F0000, 32'h0000F0F0, 5'd0,  32'h0F0FF0F0};
    tbl[5]  = '{"sll_max",   OP_SLL, 32'h0,        32'h00000001, 5'd31, 32'h80000000};
    tbl[6]  = '{"srl_max",   OP_SRL, 32'h0,        32'h80000000, 5'd31, 32'h00000001};
    tbl[7]  = '{"sub_wrap",  OP_SUB, 32'h00000000, 32'h00000001, 5'd0,  32'hFFFFFFFF};
    tbl[8]  = '{"and",       OP_AND, 32'hF0F0F0F0, 32'h3C3C3C3C, 5'd0,  32'h30303030};
    tbl[9]  = '{"nor",       OP_NOR, 32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF};
    tbl[10] = '{"slt_false", OP_SLT, 32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000};
    tbl[11] = '{"undef_c",   4'b1100, 32'h12345678, 32'h9ABCDEF0, 5'd3, 32'h00000000};
    tbl[12] = '{"sra_pos",   OP_SRA, 32'h0,        32'h7FFFFFF0, 5'd4,  32'h07FFFFFF};
    tbl[13] = '{"undef_f",   4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h00000000};

    reset = 1'b0; start_i = 1'b0; alu_operation_i = 4'h0;
    a_i = 32'h0; b_i = 32'h0; shamt_i = 5'h0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset_init");
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh, tbl[i].exp, 1, 1'b0);
    end

    // MULTU corner with a start pulse injected while busy.
    m_hi = 32'hFFFFFFFE; m_lo = 32'h00000001;
    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h00000001, 33, 1'b1);

    prod = {32'h0, 32'h12345678} * {32'h0, 32'h9ABCDEF0};
    m_hi = prod[63:32]; m_lo = prod[31:0];
    run_op("multu_mix", OP_MULTU, 32'h12345678, 32'h9ABCDEF0, 5'd0, prod[31:0], 33, 1'b0);

    run_op("and_keeps_hilo", OP_AND, 32'hFFFF0000, 32'h0000FFFF, 5'd0, 32'h00000000, 1, 1'b0);

`ifdef SEQ_ALU_DIV_EN
    m_hi = 32'd2; m_lo = 32'd14;
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd0, 32'd14, 33, 1'b0);
    m_hi = 32'd5; m_lo = 32'hFFFFFFFF;
    run_op("divu_by_zero", OP_DIVU, 32'd5, 32'd0, 5'd0, 32'hFFFFFFFF, 33, 1'b0);
`else
    run_op("divu_disabled", OP_DIVU, 32'd100, 32'd7, 5'd0, 32'h00000000, 1, 1'b0);
`endif

    // Reset ten cycles into a MULTU: aborted, no done pulse, outputs cleared.
    @(negedge clk);
    alu_operation_i = OP_MULTU; a_i = 32'h0000FFFF; b_i = 32'h0000FFFF; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_mul_busy", {63'h0, busy_o}, 64'h1);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_state("reset_mid_mul");
    reset = 1'b1;
    m_hi = 32'h0; m_lo = 32'h0;
    repeat (40) @(negedge clk);
    chk("after_abort_idle", {62'h0, busy_o, done_o}, 64'h0);
    run_op("add_after_reset", OP_ADD, 32'd2, 32'd3, 5'd0, 32'd5, 1, 1'b0);

    // Back-to-back: MULTU issued in ADD's done cycle, ADD issued in MULTU's done cycle.
    push_exp("b2b_add1", 32'd15, m_hi, m_lo);
    @(negedge clk);
    alu_operation_i = OP_ADD; a_i = 32'd7; b_i = 32'd8; start_i = 1'b1;
    @(negedge clk);
    chk("b2b_add1_done", {63'h0, done_o}, 64'h1);
    m_hi = 32'h00000003; m_lo = 32'h00000000;
    push_exp("b2b_mul", 32'h00000000, m_hi, m_lo);
    alu_operation_i = OP_MULTU; a_i = 32'h00010000; b_i = 32'h00030000;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1;
    while (!done_o && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_mul_latency", 64'(cyc), 64'd33);
    push_exp("b2b_add2", 32'd2, m_hi, m_lo);
    alu_operation_i = OP_ADD; a_i = 32'd1; b_i = 32'd1; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("b2b_add2_done", {63'h0, done_o}, 64'h1);
    @(negedge clk);
    chk("b2b_done_single_pulse", {63'h0, done_o}, 64'h0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width; legal even values 8..64.
REQ-002 SHALL have parameter SHAMT_WIDTH, default $clog2(DATA_WIDTH), shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 start_i  input  1  operation request; sampled only when busy_o=0.
REQ-006 alu_operation_i  input  4  operation code.
REQ-007 a_i, b_i  input  DATA_WIDTH each  operands.
REQ-008 shamt_i  input  SHAMT_WIDTH  shift amount.
REQ-009 busy_o  output  1  operation in progress; start_i ignored while high.
REQ-010 done_o  output  1  one-cycle pulse, result outputs valid.
REQ-011 alu_data_o  output  DATA_WIDTH  registered result.
REQ-012 zero_o  output  1  registered, high when alu_data_o==0.
REQ-013 hi_o, lo_o  output  DATA_WIDTH each  registered MULTU/DIVU result pair.

Function
REQ-014 Opcodes: LUI=0000, OR=0001, SLL=0010, ADD=0011, SRL=0100, SUB=0101, AND=0110, NOR=0111, MULTU=1000, DIVU=1001, SLT=1010, SRA=1011; all others are undefined opcodes.
REQ-015 Single-cycle ops: start_i accepted at edge N -> result registered and done_o=1 at edge N+1; busy_o stays 0.
REQ-016 ADD/SUB SHALL wrap modulo 2^DATA_WIDTH with no overflow flag; SLT SHALL return 1 if signed a_i<b_i, else 0.
REQ-017 LUI SHALL return b_i[DATA_WIDTH/2-1:0] shifted left by DATA_WIDTH/2, low half zero.
REQ-018 SLL/SRL/SRA SHALL shift b_i by shamt_i; SRA sign-extends.
REQ-019 Undefined opcodes SHALL return 0 with done_o pulsed after one cycle.
REQ-020 FSM states IDLE, MUL, DIV, DONE; IDLE->MUL on start_i with MULTU, IDLE->DIV on start_i with DIVU, MUL/DIV->DONE after DATA_WIDTH iterations, DONE->IDLE unconditionally.
REQ-021 MULTU SHALL use unsigned shift-add, one bit per cycle; {hi_o,lo_o}=a_i*b_i; alu_data_o=lo_o.
REQ-022 DIVU SHALL use unsigned restoring division, one bit per cycle; lo_o=quotient, hi_o=remainder; alu_data_o=lo_o.
REQ-023 MULTU/DIVU latency: start at edge N -> busy_o=1 from N through N+DATA_WIDTH, done_o=1 at edge N+DATA_WIDTH+1, busy_o=0 in the same cycle.
REQ-024 Operands SHALL be captured at acceptance; input changes during busy_o=1 SHALL have no effect.
REQ-025 Divide by zero SHALL yield lo_o all-ones and hi_o=a_i, with the normal latency.
REQ-026 Single-cycle ops SHALL leave hi_o/lo_o unchanged; outputs hold their values between done_o pulses.
REQ-027 start_i asserted in the done_o cycle SHALL be accepted (back-to-back issue).

Reset
REQ-028 With reset=0 at an edge: FSM->IDLE, busy_o=0, done_o=0, alu_data_o=0, hi_o=0, lo_o=0, zero_o=1.
REQ-029 Reset during MUL/DIV SHALL abort the operation without a done_o pulse; reset overrides start_i.

Configuration
REQ-030 Macro SEQ_ALU_DIV_EN: when defined, DIVU behaves per REQ-022/025; when undefined, no divider logic exists and DIVU is handled as an undefined opcode (REQ-019), hi_o/lo_o unchanged.

Structure
REQ-031 Opcode localparams and FSM state enum SHALL live in shared package alu_pkg, reused by the control unit.
REQ-032 The iterative multiply/divide datapath SHALL be sub-module seq_alu_muldiv; the single-cycle datapath stays in seq_alu.

Verification (DATA_WIDTH=32)
REQ-033 ADD 0xFFFFFFFF+1 -> alu_data_o=0, zero_o=1, done_o one cycle after start.
REQ-034 SRA b=0x80000000, shamt=4 -> 0xF8000000; SLT a=-1, b=1 -> 1; LUI b=0x1234 -> 0x12340000.
REQ-035 MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001, done_o exactly 33 cycles after start, start_i ignored while busy.
REQ-036 DIVU 100/7 -> lo_o=14, hi_o=2; DIVU 5/0 -> lo_o=0xFFFFFFFF, hi_o=5 (macro defined); macro undefined -> alu_data_o=0.
REQ-037 Reset asserted 10 cycles into MULTU -> no done_o, all outputs at reset values; next ADD 2+3 -> 5.
REQ-038 Back-to-back: start MULTU in the done_o cycle of a prior ADD, and ADD in the MULTU done_o cycle -> both accepted, correct results.
